// File: rtl/perf_counter_unit_if.sv
// ============================================================================
// Module      : perf_counter_unit_if
// Description : Event, control and readout bundle for perf_counter_unit.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface perf_counter_unit_if #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32,
  parameter int SEL_W  = 8
);
  localparam int NCNT = 2 + 2 * NUM_CH;

  logic              retire;
  logic              halt;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] hit;
  logic              clr;
  logic              snap;
  logic [SEL_W-1:0]  rd_sel;
  logic [CNT_W-1:0]  rd_data;
  logic              frozen;
  logic [NCNT-1:0]   ovf;

  modport master (
    output retire, halt, req, hit, clr, snap, rd_sel,
    input  rd_data, frozen, ovf
  );

  modport slave (
    input  retire, halt, req, hit, clr, snap, rd_sel,
    output rd_data, frozen, ovf
  );
endinterface

`default_nettype wire

// File: rtl/perf_counter_unit.sv
// ============================================================================
// Module      : perf_counter_unit
// Description : Cycle/instruction/cache performance counters with halt freeze
//               and registered readout. Optional shadow bank: PERF_SNAPSHOT_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module perf_counter_unit #(
  parameter int NUM_CH   = 2,
  parameter int CNT_W    = 32,
  parameter int SATURATE = 0,
  parameter int SEL_W    = 8
) (
  input  wire                   clk,
  input  wire                   rst,
  perf_counter_unit_if.slave    bus
);

  localparam int NCNT = 2 + 2 * NUM_CH;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_FROZEN = 1'b1
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt [NCNT];
  logic [NCNT-1:0]  r_ovf;
  logic [CNT_W-1:0] r_rdData;

  logic [NCNT-1:0]  w_inc;
  logic [CNT_W-1:0] w_nextCnt [NCNT];
  logic [NCNT-1:0]  w_nextOvf;
  logic [CNT_W-1:0] w_src [NCNT];
  logic [CNT_W-1:0] w_rdSrc;

  // Halt retires an instruction of its own, so it counts towards instr.
  assign w_inc[0] = 1'b1;
  assign w_inc[1] = bus.retire | bus.halt;

  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      assign w_inc[2 + 2 * k] = bus.req[k];
      assign w_inc[3 + 2 * k] = bus.req[k] & bus.hit[k];
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < NCNT; i++) begin
      w_nextCnt[i] = r_cnt[i];
      w_nextOvf[i] = r_ovf[i];
      if (bus.clr) begin
        w_nextCnt[i] = '0;
        w_nextOvf[i] = 1'b0;
      end else if (r_state == ST_RUN && w_inc[i]) begin
        if (&r_cnt[i]) begin
          w_nextOvf[i] = 1'b1;
          w_nextCnt[i] = (SATURATE != 0) ? r_cnt[i] : '0;
        end else begin
          w_nextCnt[i] = r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

`ifdef PERF_SNAPSHOT_EN
  logic [CNT_W-1:0] r_shadow [NCNT];

  // Shadows capture the post-edge value and survive clr.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_shadow <= '{default: '0};
    end else if (bus.snap) begin
      r_shadow <= w_nextCnt;
    end
  end

  assign w_src = r_shadow;
`else
  logic w_unusedSnap;
  assign w_unusedSnap = bus.snap;
  assign w_src        = r_cnt;
`endif

  always_comb begin
    w_rdSrc = '0;
    for (int i = 0; i < NCNT; i++) begin
      if (bus.rd_sel == SEL_W'(i)) begin
        w_rdSrc = w_src[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= ST_RUN;
      r_cnt    <= '{default: '0};
      r_ovf    <= '0;
      r_rdData <= '0;
    end else begin
      r_cnt    <= w_nextCnt;
      r_ovf    <= w_nextOvf;
      r_rdData <= w_rdSrc;
      case (r_state)
        ST_RUN: begin
          if (bus.halt && !bus.clr) begin
            r_state <= ST_FROZEN;
          end
        end
        ST_FROZEN: begin
          if (bus.clr) begin
            r_state <= ST_RUN;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign bus.rd_data = r_rdData;
  assign bus.ovf     = r_ovf;
  assign bus.frozen  = (r_state == ST_FROZEN);

endmodule

`default_nettype wire

// File: tb/tb_perf_counter_unit.sv
// ============================================================================
// Module      : tb_perf_counter_unit
// Description : Three instances (32-bit wrap, 4-bit wrap, 4-bit saturate)
//               driven in lockstep and checked against a count-based model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_perf_counter_unit;

  localparam int NDUT = 3;
  localparam int NC   = 6;
`ifdef PERF_SNAPSHOT_EN
  localparam bit SNAP_EN = 1'b1;
`else
  localparam bit SNAP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstn;
  logic       retire, halt, clr, snap;
  logic [1:0] req, hit;
  logic [7:0] rdSel;

  logic [63:0] obsRd  [NDUT];
  logic [5:0]  obsOvf [NDUT];
  logic        obsFrz [NDUT];

  always #5 clk = ~clk;

  generate
    for (genvar d = 0; d < NDUT; d++) begin : g_dut
      localparam int CW  = (d == 0) ? 32 : 4;
      localparam int SAT = (d == 2) ? 1 : 0;
      perf_counter_unit_if #(.NUM_CH(2), .CNT_W(CW), .SEL_W(8)) bus ();
      perf_counter_unit #(.NUM_CH(2), .CNT_W(CW), .SATURATE(SAT), .SEL_W(8)) dut (
        .clk (clk),
        .rst (rstn),
        .bus (bus.slave)
      );
      assign bus.retire = retire;
      assign bus.halt   = halt;
      assign bus.req    = req;
      assign bus.hit    = hit;
      assign bus.clr    = clr;
      assign bus.snap   = snap;
      assign bus.rd_sel = rdSel;
      assign obsRd[d]   = 64'(bus.rd_data);
      assign obsOvf[d]  = bus.ovf;
      assign obsFrz[d]  = bus.frozen;
    end
  endgenerate

  // Reference model: true event totals since last clear; views derived by arithmetic.
  longint unsigned tot    [NDUT][NC];
  longint unsigned shadow [NDUT][NC];
  longint unsigned expRd  [NDUT];
  logic [5:0]      expOvf [NDUT];
  bit              mFrozen;

  int nChecks = 0;
  int nBad    = 0;

  function automatic longint unsigned maxOf(int d);
    return (d == 0) ? 64'hFFFF_FFFF : 64'hF;
  endfunction

  function automatic longint unsigned viewOf(int d, longint unsigned t);
    longint unsigned mx = maxOf(d);
    if (d == 2) return (t > mx) ? mx : t;
    return t % (mx + 1);
  endfunction

  task automatic modelEdge();
    bit [5:0] inc;
    inc = {req[1] & hit[1], req[1], req[0] & hit[0], req[0], retire | halt, 1'b1};
    for (int d = 0; d < NDUT; d++) begin
      if (!rstn || rdSel >= NC) expRd[d] = 0;
      else expRd[d] = SNAP_EN ? shadow[d][rdSel] : viewOf(d, tot[d][rdSel]);
    end
    for (int d = 0; d < NDUT; d++) begin
      for (int i = 0; i < NC; i++) begin
        if (!rstn) begin
          tot[d][i]    = 0;
          shadow[d][i] = 0;
        end else begin
          if (clr) tot[d][i] = 0;
          else if (!mFrozen) tot[d][i] += inc[i];
          if (snap) shadow[d][i] = viewOf(d, tot[d][i]);
        end
        expOvf[d][i] = (tot[d][i] > maxOf(d));
      end
    end
    if (!rstn || clr) mFrozen = 1'b0;
    else if (halt) mFrozen = 1'b1;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nBad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("rd_data[dut%0d]", d), obsRd[d], expRd[d]);
      chk($sformatf("ovf[dut%0d]", d), 64'(obsOvf[d]), 64'(expOvf[d]));
      chk($sformatf("frozen[dut%0d]", d), 64'(obsFrz[d]), 64'(mFrozen));
    end
  endtask

  task automatic drive(bit rt, bit ht, bit [1:0] q, bit [1:0] t, bit c, bit s, int sel);
    retire = rt; halt = ht; req = q; hit = t; clr = c; snap = s; rdSel = 8'(sel);
  endtask

  task automatic step();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkAll();
  endtask

  initial begin
    mFrozen = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      expRd[d] = 0; expOvf[d] = '0;
      for (int i = 0; i < NC; i++) begin tot[d][i] = 0; shadow[d][i] = 0; end
    end

    // Reset overrides clr/halt/snap.
    rstn = 1'b0;
    drive(1, 1, 2'b11, 2'b11, 1, 1, 0);
    repeat (3) step();
    rstn = 1'b1;

    drive(0, 0, 2'b00, 2'b00, 0, 0, 1);
    repeat (10) step();
    drive(0, 0, 2'b00, 2'b00, 0, 0, 0);
    step();
`ifndef PERF_SNAPSHOT_EN
    chk("plan_cycles10", obsRd[0], 64'd10);
`endif
    drive(0, 0, 2'b00, 2'b00, 0, 0, 1);
    step();
    chk("plan_instr0", obsRd[0], 64'd0);

    // Per-channel request/hit counting.
    drive(0, 0, 2'b00, 2'b00, 1, 0, 0);
    step();
    drive(0, 0, 2'b11, 2'b01, 0, 0, 0);
    repeat (6) step();
    drive(0, 0, 2'b00, 2'b11, 0, 0, 0);
    repeat (2) step();
    for (int i = 2; i < 6; i++) begin
      drive(0, 0, 2'b00, 2'b00, 0, 0, i);
      step();
`ifndef PERF_SNAPSHOT_EN
      chk($sformatf("plan_ch_idx%0d", i), obsRd[0], (i == 5) ? 64'd0 : 64'd6);
`endif
    end

    // Retire then halt, then toggling inputs while frozen.
    drive(0, 0, 2'b00, 2'b00, 1, 0, 0);
    step();
    drive(1, 0, 2'b00, 2'b00, 0, 0, 0);
    repeat (5) step();
    drive(0, 1, 2'b00, 2'b00, 0, 0, 0);
    step();
    repeat (20) begin
      drive(1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom), 0, 0, 0);
      step();
    end
    drive(0, 0, 2'b00, 2'b00, 0, 0, 1);
    step();
    chk("plan_frozen", 64'(obsFrz[0]), 64'd1);
`ifndef PERF_SNAPSHOT_EN
    chk("plan_instr6", obsRd[0], 64'd6);
`endif
    drive(0, 0, 2'b00, 2'b00, 0, 0, 0);
    step();
`ifndef PERF_SNAPSHOT_EN
    chk("plan_cycles_frozen", obsRd[0], 64'd6);
`endif
    drive(0, 0, 2'b00, 2'b00, 1, 0, 0);
    step();
    chk("plan_unfrozen", 64'(obsFrz[0]), 64'd0);
    drive(0, 0, 2'b00, 2'b00, 0, 0, 0);
    step();
`ifndef PERF_SNAPSHOT_EN
    chk("plan_clr_cycles", obsRd[0], 64'd0);
`endif

    // Overflow on 4-bit counters: 17 counted cycles from zero.
    drive(0, 0, 2'b00, 2'b00, 1, 0, 0);
    step();
    drive(0, 0, 2'b00, 2'b00, 0, 0, 0);
    repeat (17) step();
    step();
`ifndef PERF_SNAPSHOT_EN
    chk("plan_wrap_cycles", obsRd[1], 64'd1);
    chk("plan_sat_cycles", obsRd[2], 64'd15);
`endif
    chk("plan_wrap_ovf0", 64'(obsOvf[1][0]), 64'd1);
    chk("plan_sat_ovf0", 64'(obsOvf[2][0]), 64'd1);

    // clr and halt together: clr wins; out-of-range select reads zero.
    drive(0, 1, 2'b11, 2'b11, 1, 0, 0);
    step();
    chk("plan_clr_halt_frozen", 64'(obsFrz[0]), 64'd0);
    chk("plan_clr_ovf", 64'(obsOvf[1]), 64'd0);
    drive(0, 0, 2'b00, 2'b00, 0, 0, NC + 3);
    step();
    step();
    chk("plan_sel_oob", obsRd[0], 64'd0);

`ifdef PERF_SNAPSHOT_EN
    drive(0, 0, 2'b00, 2'b00, 1, 0, 0);
    step();
    drive(0, 0, 2'b00, 2'b00, 0, 0, 0);
    repeat (7) step();
    drive(0, 0, 2'b00, 2'b00, 0, 1, 0);
    step();
    drive(0, 0, 2'b00, 2'b00, 0, 0, 0);
    repeat (5) step();
    step();
    chk("plan_snap8", obsRd[0], 64'd8);
    drive(0, 0, 2'b00, 2'b00, 1, 0, 0);
    step();
    drive(0, 0, 2'b00, 2'b00, 0, 0, 0);
    step();
    chk("plan_snap_after_clr", obsRd[0], 64'd8);
`endif

    // Randomized traffic with occasional clr, halt, snap and reset.
    repeat (400) begin
      rstn = ($urandom_range(0, 49) != 0);
      drive(1'($urandom), ($urandom_range(0, 15) == 0), 2'($urandom), 2'($urandom),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
            int'($urandom_range(0, 9)));
      step();
    end
    rstn = 1'b1;

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule

`default_nettype wire
